// File: rtl/frame_line_sequencer_if.sv
// frame_line_sequencer_if
//  Groups the engine-side and line-buffer-side signals of the frame line
//  sequencer into one bundle.
//  Engine side : line_start (to engine), line_done, eng_we, eng_addr, eng_depth
//                (from engine).
//  Buffer side : buf_we, buf_addr {bank, x}, buf_data (write port into the
//                ping-pong line buffer), line_valid / line_y0 / line_y1
//                (per-bank ready flags and row numbers), line_release (from
//                the display consumer, one bit per bank).
//  Modports    : master = the sequencer, slave = engine plus consumer view.
interface frame_line_sequencer_if;
  logic        line_start;
  logic        line_done;
  logic        eng_we;
  logic [9:0]  eng_addr;
  logic [9:0]  eng_depth;
  logic        buf_we;
  logic [10:0] buf_addr;
  logic [9:0]  buf_data;
  logic [1:0]  line_valid;
  logic [8:0]  line_y0;
  logic [8:0]  line_y1;
  logic [1:0]  line_release;

  modport master (
    output line_start,
    input  line_done,
    input  eng_we,
    input  eng_addr,
    input  eng_depth,
    output buf_we,
    output buf_addr,
    output buf_data,
    output line_valid,
    output line_y0,
    output line_y1,
    input  line_release
  );

  modport slave (
    input  line_start,
    output line_done,
    output eng_we,
    output eng_addr,
    output eng_depth,
    input  buf_we,
    input  buf_addr,
    input  buf_data,
    input  line_valid,
    input  line_y0,
    input  line_y1,
    output line_release
  );
endinterface

// File: rtl/frame_line_sequencer.sv
// frame_line_sequencer
//  Frame-level scheduler for the Mandelbrot line engine. Issues one
//  line-start pulse per row, steers the engine's (x, depth) write stream into
//  one of two ping-pong line-buffer banks, marks finished banks as ready for
//  the display side and latches the view configuration once per frame.
//
//  Ports
//   clk, reset              clock and synchronous active-high reset
//   frame_req               request a new frame (accepted only when idle)
//   cfg_zoom / cfg_*_center live view configuration from the register block
//   zoom_q / *_center_q     frame-stable copies handed to the engine
//   cur_y                   row currently being computed
//   busy                    high whenever a frame is in progress
//   frame_done              one-cycle pulse once the last row's bank is filled
//   frame_cycles            (only with SEQ_PERF_CNT_EN) busy cycles of the
//                           current / most recent frame
//   bus                     engine + line-buffer bundle (master modport)
//
//  Build option: define SEQ_PERF_CNT_EN to add the frame_cycles counter.
module frame_line_sequencer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int WORD_LENGTH   = 32,
  parameter int ZOOM_W        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_req,
  input  logic [ZOOM_W-1:0]      cfg_zoom,
  input  logic [WORD_LENGTH-1:0] cfg_real_center,
  input  logic [WORD_LENGTH-1:0] cfg_imag_center,
  output logic [ZOOM_W-1:0]      zoom_q,
  output logic [WORD_LENGTH-1:0] real_center_q,
  output logic [WORD_LENGTH-1:0] imag_center_q,
  output logic [8:0]             cur_y,
  output logic                   busy,
  output logic                   frame_done,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]            frame_cycles,
`endif
  frame_line_sequencer_if.master bus
);

  localparam logic [8:0]             LAST_Y     = 9'(SCREEN_HEIGHT - 1);
  localparam logic [10:0]            X_LIMIT    = 11'(SCREEN_WIDTH);
  localparam logic [WORD_LENGTH-1:0] REAL_RESET = {2'b11, {(WORD_LENGTH-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_BUF,
    S_CALC,
    S_NEXT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       wr_bank;
  logic       line_done_prev;
  logic       done_rise;
  logic       accept;
  logic       last_line;
  logic [1:0] bank_set;

  assign done_rise = bus.line_done & ~line_done_prev;
  assign last_line = (cur_y == LAST_Y);
  assign busy      = (state != S_IDLE);

  // S_ARM lasts exactly one cycle, so gating it with the target bank being
  // free gives a single-cycle start pulse; a full bank diverts to S_WAIT_BUF.
  assign bus.line_start = (state == S_ARM) && !bus.line_valid[wr_bank];
  assign frame_done     = (state == S_NEXT) && last_line;

  // Bank that the current row just finished filling; only meaningful on the
  // line_done rising edge while calculating.
  assign bank_set = (state == S_CALC && done_rise) ?
                    (wr_bank ? 2'b10 : 2'b01) : 2'b00;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic for the row sequencer.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_req) begin
          accept    = 1'b1;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (!bus.line_valid[wr_bank]) begin
          state_nxt = S_CALC;
        end else begin
          state_nxt = S_WAIT_BUF;
        end
      end
      S_WAIT_BUF: begin
        if (!bus.line_valid[wr_bank]) begin
          state_nxt = S_ARM;
        end
      end
      S_CALC: begin
        if (done_rise) begin
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (last_line) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_ARM;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame configuration snapshot, row counter and bank selector. The view
  // config is only sampled on frame acceptance so the engine never sees a
  // zoom/centre change part way through a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      zoom_q        <= ZOOM_W'(1);
      real_center_q <= REAL_RESET;
      imag_center_q <= '0;
      cur_y         <= '0;
      wr_bank       <= 1'b0;
    end else if (accept) begin
      zoom_q        <= cfg_zoom;
      real_center_q <= cfg_real_center;
      imag_center_q <= cfg_imag_center;
      cur_y         <= '0;
      wr_bank       <= 1'b0;
    end else if (state == S_NEXT) begin
      if (last_line) begin
        cur_y <= '0;
      end else begin
        cur_y   <= cur_y + 9'd1;
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Bank ready flags and their row numbers. Releases clear first and the
  // completion set is OR-ed in afterwards, so a release racing the fill of
  // the same bank loses and the freshly finished line is not thrown away.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.line_valid <= 2'b00;
      bus.line_y0    <= '0;
      bus.line_y1    <= '0;
      line_done_prev <= 1'b0;
    end else begin
      line_done_prev <= bus.line_done;
      bus.line_valid <= (bus.line_valid & ~bus.line_release) | bank_set;
      if (bank_set[0]) begin
        bus.line_y0 <= cur_y;
      end
      if (bank_set[1]) begin
        bus.line_y1 <= cur_y;
      end
    end
  end

  // Registered write forwarding into the line buffer. Writes outside a row
  // calculation, or with an x beyond the visible line, are dropped so the
  // buffer only ever holds data for the row that owns the bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.buf_we   <= 1'b0;
      bus.buf_addr <= '0;
      bus.buf_data <= '0;
    end else begin
      bus.buf_we <= 1'b0;
      if (state == S_CALC && bus.eng_we && ({1'b0, bus.eng_addr} < X_LIMIT)) begin
        bus.buf_we   <= 1'b1;
        bus.buf_addr <= {wr_bank, bus.eng_addr};
        bus.buf_data <= bus.eng_depth;
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Frame length counter: restarts on acceptance, counts every busy cycle and
  // naturally holds once the FSM returns to idle after frame_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cycles <= '0;
    end else if (accept) begin
      frame_cycles <= '0;
    end else if (busy) begin
      frame_cycles <= frame_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_line_sequencer.sv
// tb_frame_line_sequencer
//  Directed bench for frame_line_sequencer built with a 4-row screen so whole
//  frames fit in a short run. Drives the engine and consumer sides through
//  the interface, checks reset values, write forwarding, ping-pong banking,
//  back-pressure, config latching, release/set collision and mid-line reset.
module tb_frame_line_sequencer;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_req;
  logic [15:0] cfg_zoom;
  logic [31:0] cfg_real_center;
  logic [31:0] cfg_imag_center;
  logic [15:0] zoom_q;
  logic [31:0] real_center_q;
  logic [31:0] imag_center_q;
  logic [8:0]  cur_y;
  logic        busy;
  logic        frame_done;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] frame_cycles;
  int          busyCycles;
`endif

  int assertCount = 0;
  int failCount   = 0;
  int waited;
  int starts;

  frame_line_sequencer_if bus_if ();

  frame_line_sequencer #(
    .SCREEN_WIDTH (640),
    .SCREEN_HEIGHT(H),
    .WORD_LENGTH  (32),
    .ZOOM_W       (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_req      (frame_req),
    .cfg_zoom       (cfg_zoom),
    .cfg_real_center(cfg_real_center),
    .cfg_imag_center(cfg_imag_center),
    .zoom_q         (zoom_q),
    .real_center_q  (real_center_q),
    .imag_center_q  (imag_center_q),
    .cur_y          (cur_y),
    .busy           (busy),
    .frame_done     (frame_done),
`ifdef SEQ_PERF_CNT_EN
    .frame_cycles   (frame_cycles),
`endif
    .bus            (bus_if.master)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

`ifdef SEQ_PERF_CNT_EN
  // Independent count of busy cycles for the frame in flight.
  always @(posedge clk) begin
    if (reset) busyCycles <= 0;
    else if (frame_req && !busy) busyCycles <= 0;
    else if (busy) busyCycles <= busyCycles + 1;
  end
`endif

  // One comparison: counts it, and reports the tag with both values on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) on negedges until line_start is seen; waited = edges used.
  task automatic waitLineStart(input int maxCycles, output int w);
    w = 0;
    while (bus_if.line_start !== 1'b1 && w < maxCycles) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Engine model for one row: n writes x0.., depth d0.., raising line_done
  // together with the final write and driving rel on the consumer side in
  // that same cycle. Returns at the negedge where the FSM sits in S_NEXT.
  task automatic applyStimulus(input logic bank, input int x0, input int n,
                               input int d0, input logic [1:0] rel);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checkOutput("buf_we", {31'd0, bus_if.buf_we}, 32'd1);
        checkOutput("buf_addr", {21'd0, bus_if.buf_addr}, {21'd0, bank, 10'(x0 + k - 1)});
        checkOutput("buf_data", {22'd0, bus_if.buf_data}, 32'(d0 + k - 1));
      end
      bus_if.eng_we    = 1'b1;
      bus_if.eng_addr  = 10'(x0 + k);
      bus_if.eng_depth = 10'(d0 + k);
      if (k == n - 1) begin
        bus_if.line_done    = 1'b1;
        bus_if.line_release = rel;
      end
    end
    @(negedge clk);
    bus_if.eng_we       = 1'b0;
    bus_if.line_done    = 1'b0;
    bus_if.line_release = 2'b00;
    checkOutput("buf_we_last", {31'd0, bus_if.buf_we}, 32'd1);
    checkOutput("buf_addr_last", {21'd0, bus_if.buf_addr}, {21'd0, bank, 10'(x0 + n - 1)});
    checkOutput("buf_data_last", {22'd0, bus_if.buf_data}, 32'(d0 + n - 1));
  endtask

  initial begin
    reset               = 1'b1;
    frame_req           = 1'b0;
    cfg_zoom            = 16'd1;
    cfg_real_center     = 32'h0;
    cfg_imag_center     = 32'h0;
    bus_if.line_done    = 1'b0;
    bus_if.eng_we       = 1'b0;
    bus_if.eng_addr     = '0;
    bus_if.eng_depth    = '0;
    bus_if.line_release = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset values
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_line_start", {31'd0, bus_if.line_start}, 32'd0);
    checkOutput("rst_line_valid", {30'd0, bus_if.line_valid}, 32'd0);
    checkOutput("rst_cur_y", {23'd0, cur_y}, 32'd0);
    checkOutput("rst_zoom_q", {16'd0, zoom_q}, 32'd1);
    checkOutput("rst_real_q", real_center_q, 32'hC0000000);
    checkOutput("rst_imag_q", imag_center_q, 32'd0);
    checkOutput("rst_buf_we", {31'd0, bus_if.buf_we}, 32'd0);
    checkOutput("rst_buf_addr", {21'd0, bus_if.buf_addr}, 32'd0);
    checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);

    // Engine write while idle is dropped
    bus_if.eng_we = 1'b1; bus_if.eng_addr = 10'd3; bus_if.eng_depth = 10'd9;
    @(negedge clk);
    bus_if.eng_we = 1'b0;
    checkOutput("idle_we_dropped", {31'd0, bus_if.buf_we}, 32'd0);

    // Frame 1 acceptance latches config
    cfg_zoom = 16'd1; cfg_real_center = 32'h12345678; cfg_imag_center = 32'h0ABCDEF0;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checkOutput("f1_busy", {31'd0, busy}, 32'd1);
    checkOutput("f1_line_start_y0", {31'd0, bus_if.line_start}, 32'd1);
    checkOutput("f1_zoom_q", {16'd0, zoom_q}, 32'd1);
    checkOutput("f1_real_q", real_center_q, 32'h12345678);
    checkOutput("f1_imag_q", imag_center_q, 32'h0ABCDEF0);
    checkOutput("f1_cur_y0", {23'd0, cur_y}, 32'd0);
    cfg_zoom = 16'd4; cfg_real_center = 32'h0FEDCBA9;

    // Row 0 into bank 0, first write x=5 depth=200
    applyStimulus(1'b0, 5, 3, 200, 2'b00);
    checkOutput("y0_valid", {30'd0, bus_if.line_valid}, 32'd1);
    checkOutput("y0_line_y0", {23'd0, bus_if.line_y0}, 32'd0);
    checkOutput("y0_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("y0_zoom_held", {16'd0, zoom_q}, 32'd1);

    // Row 1 into bank 1
    waitLineStart(4, waited);
    checkOutput("y1_line_start", {31'd0, bus_if.line_start}, 32'd1);
    checkOutput("y1_cur_y", {23'd0, cur_y}, 32'd1);
    applyStimulus(1'b1, 0, 2, 50, 2'b00);
    checkOutput("y1_valid", {30'd0, bus_if.line_valid}, 32'd3);
    checkOutput("y1_line_y1", {23'd0, bus_if.line_y1}, 32'd1);

    // Both banks full: no third start
    starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_if.line_start === 1'b1) starts++;
    end
    checkOutput("stall_no_start", 32'(starts), 32'd0);
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    checkOutput("stall_cur_y", {23'd0, cur_y}, 32'd2);

    // Release bank 0 -> start two cycles later
    bus_if.line_release = 2'b01;
    @(negedge clk);
    bus_if.line_release = 2'b00;
    checkOutput("rel0_valid", {30'd0, bus_if.line_valid}, 32'd2);
    waitLineStart(4, waited);
    checkOutput("rel0_line_start", {31'd0, bus_if.line_start}, 32'd1);
    checkOutput("rel0_latency", 32'(waited), 32'd1);

    // Row 2 into bank 0, last x with max depth
    applyStimulus(1'b0, 639, 1, 1023, 2'b00);
    checkOutput("y2_valid", {30'd0, bus_if.line_valid}, 32'd3);
    checkOutput("y2_line_y0", {23'd0, bus_if.line_y0}, 32'd2);

    // Release bank 1 for row 3
    @(negedge clk);
    bus_if.line_release = 2'b10;
    @(negedge clk);
    bus_if.line_release = 2'b00;
    waitLineStart(4, waited);
    checkOutput("y3_line_start", {31'd0, bus_if.line_start}, 32'd1);
    checkOutput("y3_cur_y", {23'd0, cur_y}, 32'd3);

    // Row 3: release of both banks collides with bank 1 set -> set wins
    applyStimulus(1'b1, 10, 2, 300, 2'b11);
    checkOutput("y3_valid_setwins", {30'd0, bus_if.line_valid}, 32'd2);
    checkOutput("y3_line_y1", {23'd0, bus_if.line_y1}, 32'd3);
    checkOutput("y3_frame_done", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    checkOutput("end_frame_done_pulse", {31'd0, frame_done}, 32'd0);
    checkOutput("end_busy", {31'd0, busy}, 32'd0);
    checkOutput("end_cur_y", {23'd0, cur_y}, 32'd0);
    checkOutput("end_zoom_held", {16'd0, zoom_q}, 32'd1);
`ifdef SEQ_PERF_CNT_EN
    checkOutput("frame_cycles", frame_cycles, 32'(busyCycles));
`endif

    // Frame 2 picks up the new config
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    checkOutput("f2_zoom_q", {16'd0, zoom_q}, 32'd4);
    checkOutput("f2_real_q", real_center_q, 32'h0FEDCBA9);
    checkOutput("f2_line_start", {31'd0, bus_if.line_start}, 32'd1);

    // frame_req while busy ignored
    cfg_zoom  = 16'd7;
    frame_req = 1'b1;
    applyStimulus(1'b0, 1, 1, 7, 2'b00);
    frame_req = 1'b0;
    checkOutput("f2_busy_req_zoom", {16'd0, zoom_q}, 32'd4);
    checkOutput("f2_cur_y", {23'd0, cur_y}, 32'd0);
    checkOutput("f2_valid", {30'd0, bus_if.line_valid}, 32'd3);

    // Start row 1 then reset mid-line
    @(negedge clk);
    bus_if.line_release = 2'b10;
    @(negedge clk);
    bus_if.line_release = 2'b00;
    waitLineStart(4, waited);
    checkOutput("f2_y1_start", {31'd0, bus_if.line_start}, 32'd1);
    @(negedge clk);
    bus_if.eng_we = 1'b1; bus_if.eng_addr = 10'd20; bus_if.eng_depth = 10'd5;
    @(negedge clk);
    bus_if.eng_we = 1'b0;
    checkOutput("f2_y1_buf_addr", {21'd0, bus_if.buf_addr}, 32'h414);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_valid", {30'd0, bus_if.line_valid}, 32'd0);
    checkOutput("mid_rst_cur_y", {23'd0, cur_y}, 32'd0);
    checkOutput("mid_rst_line_start", {31'd0, bus_if.line_start}, 32'd0);
    checkOutput("mid_rst_buf_we", {31'd0, bus_if.buf_we}, 32'd0);
    checkOutput("mid_rst_zoom_q", {16'd0, zoom_q}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
